// File: rtl/ps2_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_transmitter
// Brief    : Host-to-device PS/2 command transmitter (RTS, shift, ACK check).
// Revision : 1.0
// ============================================================================
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_SHIFT    = 3'd3,
        S_ACK      = 3'd4,
        S_WAITIDLE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_clk_meta, r_clk_sync, r_clk_prev;
    logic                 r_dat_meta, r_dat_sync;
    logic [9:0]           r_frame;
    logic [3:0]           r_bit_cnt;
    logic [c_INH_W-1:0]   r_inh_cnt;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic                 r_clock_oe, r_data_oe, r_busy, r_ready, r_done, r_error;
    logic                 w_fe, w_timing, w_timeout;
    logic                 w_data_oe_next, w_done, w_error;

    assign w_fe      = r_clk_prev & ~r_clk_sync;
    assign w_timing  = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAITIDLE);
    assign w_timeout = w_timing && !w_fe && (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_next         = r_state;
        w_data_oe_next = r_data_oe;
        w_done         = 1'b0;
        w_error        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_valid && r_ready) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (r_inh_cnt == c_INH_LAST) begin
                    w_next         = S_REQ;
                    w_data_oe_next = 1'b1;
                end
            end
            S_REQ: begin
                w_next         = S_SHIFT;
                w_data_oe_next = 1'b1;
            end
            S_SHIFT: begin
                if (w_fe) begin
                    w_data_oe_next = ~r_frame[0];
                    if (r_bit_cnt == 4'd9) w_next = S_ACK;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                end
            end
            S_ACK: begin
                if (w_fe) begin
                    if (r_dat_sync) w_error = 1'b1;
                    else            w_next  = S_WAITIDLE;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                end
            end
            S_WAITIDLE: begin
                if (r_clk_sync && r_dat_sync) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_error) w_next = S_IDLE;
        // Lines are released in the very cycle the block returns to IDLE.
        if (w_next == S_IDLE) w_data_oe_next = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_clock_oe <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_clk_meta <= ps2_clock_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_data_in;
            r_dat_sync <= r_dat_meta;
            r_state    <= w_next;
            r_clock_oe <= (w_next == S_INHIBIT) || (w_next == S_REQ);
            r_data_oe  <= w_data_oe_next;
            r_busy     <= (w_next != S_IDLE);
            r_ready    <= (r_state == S_IDLE) && (w_next == S_IDLE);
            r_done     <= w_done;
            r_error    <= w_error;

            if (r_state == S_IDLE && w_next == S_INHIBIT)
                r_frame <= {1'b1, ~^tx_data, tx_data};
            else if (r_state == S_SHIFT && w_fe)
                r_frame <= r_frame >> 1;

            if (r_state == S_SHIFT) begin
                if (w_fe) r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
                r_bit_cnt <= '0;
            end

            r_inh_cnt <= (r_state == S_INHIBIT) ? r_inh_cnt + 1'b1 : '0;
            r_to_cnt  <= (w_timing && !w_fe) ? r_to_cnt + 1'b1 : '0;
        end
    end

    assign tx_ready     = r_ready;
    assign busy         = r_busy;
    assign ps2_clock_oe = r_clock_oe;
    assign ps2_data_oe  = r_data_oe;
    assign tx_done      = r_done;
    assign tx_error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_transmitter
// Brief    : Randomized bench with a PS/2 device model for ps2_transmitter.
// Revision : 1.0
// ============================================================================
module tb_ps2_transmitter;

    localparam int INH = 20;
    localparam int TO  = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clock_oe, ps2_data_oe, busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       pad_clk, pad_data;

    assign pad_clk  = ~(ps2_clock_oe | dev_clk_low);
    assign pad_data = ~(ps2_data_oe | dev_data_low);

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clock_in(pad_clk),
        .ps2_data_in (pad_data),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    always #5 clock = ~clock;

    int   n_checks = 0, n_fail = 0;
    int   done_cnt = 0, err_cnt = 0, acc_cnt = 0;
    logic pulse_oe = 1'b1, pulse_busy = 1'b1, ready_after = 1'b0, prev_pulse = 1'b0;

    // Event monitor: values read at posedge belong to the cycle just ending.
    always @(posedge clock) begin
        if (tx_valid && tx_ready && !reset) acc_cnt <= acc_cnt + 1;
        if (tx_done)  done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt  <= err_cnt + 1;
        if (prev_pulse) ready_after <= tx_ready;
        if (tx_done || tx_error) begin
            pulse_oe   <= ps2_clock_oe | ps2_data_oe;
            pulse_busy <= busy;
        end
        prev_pulse <= tx_done | tx_error;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = b[i];
        f[8] = ($countones(b) % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 1000) begin tick(1); t++; end
        check_eq("send_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_shift();
        int t = 0;
        while (!(ps2_clock_oe == 1'b0 && ps2_data_oe == 1'b1 && busy) && t < 200) begin
            tick(1); t++;
        end
        check_eq("shift_wait", {31'd0, busy & ps2_data_oe & ~ps2_clock_oe}, 32'd1);
    endtask

    task automatic device_run(input logic ack, input int abort_at, output logic [9:0] bits);
        bits = '0;
        wait_shift();
        tick(5);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            tick(20);
            dev_clk_low = 1'b0;
            bits[i] = pad_data;
            if (i == abort_at) return;
            tick(20);
        end
        dev_data_low = ack;
        tick(5);
        dev_clk_low = 1'b1;
        tick(20);
        dev_clk_low = 1'b0;
        tick(20);
        dev_data_low = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input logic [7:0] b, input logic ack,
                               input int d0, input int e0, input logic [9:0] bits);
        int t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 100) begin tick(1); t++; end
        tick(3);
        check_eq({tag, "_frame"}, {22'd0, bits}, {22'd0, exp_frame(b)});
        check_eq({tag, "_done"}, done_cnt - d0, ack ? 32'd1 : 32'd0);
        check_eq({tag, "_err"},  err_cnt - e0,  ack ? 32'd0 : 32'd1);
        check_eq({tag, "_pulse_oe"}, {31'd0, pulse_oe}, 32'd0);
        check_eq({tag, "_pulse_busy"}, {31'd0, pulse_busy}, 32'd0);
        check_eq({tag, "_ready_after"}, {31'd0, ready_after}, 32'd1);
    endtask

    task automatic do_xfer(input string tag, input logic [7:0] b, input logic ack,
                           output logic [9:0] bits);
        int d0 = done_cnt, e0 = err_cnt;
        send_byte(b);
        device_run(ack, -1, bits);
        finish_xfer(tag, b, ack, d0, e0, bits);
    endtask

    initial begin
        logic [9:0] bits;
        int d0, e0, a0, t;
        logic inh_ok;

        tick(3);
        check_eq("rst_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_oe",    {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
        check_eq("rst_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        reset = 1'b0;
        tick(2);

        // 0xED with cycle-exact request-to-send timing
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hED);
        check_eq("ed_busy",  {31'd0, busy}, 32'd1);
        check_eq("ed_ready", {31'd0, tx_ready}, 32'd0);
        inh_ok = 1'b1;
        for (int i = 0; i < INH; i++) begin
            if (!(ps2_clock_oe === 1'b1 && ps2_data_oe === 1'b0 && busy === 1'b1)) inh_ok = 1'b0;
            tick(1);
        end
        check_eq("ed_inhibit", {31'd0, inh_ok}, 32'd1);
        check_eq("ed_req", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd3);
        tick(1);
        check_eq("ed_shift", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd1);
        device_run(1'b1, -1, bits);
        finish_xfer("ed", 8'hED, 1'b1, d0, e0, bits);
        check_eq("ed_bits_lit", {22'd0, bits}, 32'h3ED);

        do_xfer("b01", 8'h01, 1'b1, bits);
        check_eq("b01_parity", {31'd0, bits[8]}, 32'd0);
        do_xfer("b00", 8'h00, 1'b1, bits);
        check_eq("b00_parity", {31'd0, bits[8]}, 32'd1);

        for (int k = 0; k < 4; k++) do_xfer("rand", 8'($urandom), 1'b1, bits);

        do_xfer("noack", 8'($urandom), 1'b0, bits);

        // Device never clocks: timeout measured from first SHIFT cycle
        send_byte(8'h3C);
        wait_shift();
        t = 0;
        while (!tx_error && t < 400) begin tick(1); t++; end
        check_eq("to_cycles", t, TO);
        check_eq("to_oe", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
        tick(2);
        check_eq("to_ready", {31'd0, tx_ready}, 32'd1);

        // tx_valid held for the whole transfer
        a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        device_run(1'b1, -1, bits);
        finish_xfer("hold", 8'hFF, 1'b1, d0, e0, bits);
        check_eq("hold_accepts", acc_cnt - a0, 32'd2);
        check_eq("hold_rebusy", {31'd0, busy}, 32'd1);
        tx_valid = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);

        // Reset during data bit 3
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        device_run(1'b1, 3, bits);
        tick(3);
        check_eq("mid_pre_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        reset = 1'b1;
        tick(1);
        check_eq("mid_oe", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        reset = 1'b0;
        tick(10);
        check_eq("mid_no_events", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        do_xfer("f4", 8'hF4, 1'b1, bits);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
